// File: rtl/uart_rx_os16_pkg.sv
// Shared encodings for the 16x oversampled UART receiver.
// Frame-timing constants are expressed in oversample ticks.
package uart_rx_os16_pkg;

    typedef enum logic [2:0] {
        UR_IDLE,
        UR_START,
        UR_DATA,
        UR_STOP,
        UR_BREAK
    } ur_state_t;

    localparam int OS_RATE = 16;
    localparam int OS_MID  = 7;
    localparam int OS_LAST = 15;

endpackage

// File: rtl/uart_rx_os16_if.sv
// Processor-side bus of the UART receiver.
// Pop-on-read byte stream plus sticky error flags.
interface uart_rx_os16_if;

    logic       rd;
    logic       clr_err;
    logic [7:0] dout;
    logic       avail;
    logic       overrun;
    logic       ferr;

    modport master (
        output rd, clr_err,
        input  dout, avail, overrun, ferr
    );

    modport slave (
        input  rd, clr_err,
        output dout, avail, overrun, ferr
    );

endinterface

// File: rtl/uart_rx_os16_fifo.sv
// Small power-of-two receive FIFO.
// Pointers carry an extra wrap bit to tell full from empty.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
    // A pop in the same clk frees the slot a full push needs.
    assign wr_en = push && (!full || (pop && !empty));
    assign rd_en = pop && !empty;
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampling, small receive FIFO.
// Start-edge detection realigns the tick phase to the frame.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RxD,
    input  logic [DIV_W-1:0] baud_div,
    output logic             busy,
    uart_rx_os16_if.slave    bus
);

    ur_state_t        state;
    logic             s1;
    logic             rxs;
    logic [DIV_W-1:0] cnt;
    logic             tick;
    logic [3:0]       sc;
    logic [2:0]       bi;
    logic [7:0]       shreg;
    logic             push_q;
    logic [7:0]       push_data;
    logic             ferr;
    logic             overrun;
    logic             empty;
    logic             full;
    logic             ov_set;
    logic             start_det;

    assign tick      = (cnt == '0);
    assign start_det = (state == UR_IDLE) && !rxs;
    assign busy      = (state != UR_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= 1'b1;
            rxs <= 1'b1;
        end else begin
            s1  <= RxD;
            rxs <= s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (start_det || tick)
            cnt <= baud_div;
        else
            cnt <= cnt - DIV_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= UR_IDLE;
            sc        <= '0;
            bi        <= '0;
            shreg     <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
            ferr      <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (bus.clr_err) ferr <= 1'b0;
            unique case (state)
                UR_IDLE: begin
                    if (!rxs) begin
                        sc    <= '0;
                        state <= UR_START;
                    end
                end
                UR_START: begin
                    if (tick) begin
                        if (sc == 4'(OS_MID)) begin
                            sc <= '0;
                            bi <= '0;
                            state <= rxs ? UR_IDLE : UR_DATA;
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                UR_DATA: begin
                    if (tick) begin
                        if (sc == 4'(OS_LAST)) begin
                            sc    <= '0;
                            shreg <= {rxs, shreg[7:1]};
                            if (bi == 3'd7) state <= UR_STOP;
                            else bi <= bi + 3'd1;
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                UR_STOP: begin
                    if (tick) begin
                        if (sc == 4'(OS_LAST)) begin
                            sc <= '0;
                            if (rxs) begin
                                push_q    <= 1'b1;
                                push_data <= shreg;
                                state     <= UR_IDLE;
                            end else begin
                                ferr  <= 1'b1;
                                state <= UR_BREAK;
                            end
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                UR_BREAK: begin
                    if (rxs) state <= UR_IDLE;
                end
                default: state <= UR_IDLE;
            endcase
        end
    end

    assign ov_set = push_q && full && !(bus.rd && !empty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overrun <= 1'b0;
        else if (ov_set)
            overrun <= 1'b1;
        else if (bus.clr_err)
            overrun <= 1'b0;
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .din   (push_data),
        .pop   (bus.rd),
        .dout  (bus.dout),
        .empty (empty),
        .full  (full)
    );

    assign bus.avail   = !empty;
    assign bus.overrun = overrun;
    assign bus.ferr    = ferr;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: directed frames, expected bytes queued
// by stimulus and popped/compared by an independent monitor.
module tb_uart_rx_os16;

    localparam int BIT_CLK  = 224;
    localparam int FRAME    = 10 * BIT_CLK;
    // start edge driven at c=0: sync 2 clk, detect at clk 3,
    // stop sampled 152 ticks of 14 clk later, written one clk after
    localparam int PUSH_AT  = 3 + 14 * 152 - 1 + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RxD = 1'b1;
    logic [15:0] baud_div = 16'd13;
    logic        busy;
    logic        rd_mon = 1'b0;
    logic        rd_stim = 1'b0;
    logic        clr_stim = 1'b0;
    logic        auto_rd = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  q[$];

    uart_rx_os16_if bus();

    assign bus.rd      = rd_mon | rd_stim;
    assign bus.clr_err = clr_stim;

    uart_rx_os16 #(
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .RxD      (RxD),
        .baud_div (baud_div),
        .busy     (busy),
        .bus      (bus)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 1: rd on push clk; 2: clr_err on push clk; 3: reset mid-frame
    task automatic send(input logic [7:0] b, input logic stop,
                        input int mode);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            RxD = fr[c / BIT_CLK];
            if (mode == 1) rd_stim = (c == PUSH_AT - 1);
            if (mode == 2) clr_stim = (c == PUSH_AT - 1);
            if (mode == 1 && c == PUSH_AT - 1) begin
                chk("simul_avail", 8'(bus.avail), 8'd1);
                chk("simul_head", bus.dout, q.pop_front());
            end
            if (mode == 3 && c == 1150) rst_n = 1'b0;
            if (mode == 3 && c == 1400) begin
                chk("rst_dout", bus.dout, 8'h00);
                chk("rst_avail", 8'(bus.avail), 8'd0);
                chk("rst_busy", 8'(busy), 8'd0);
                chk("rst_ovr", 8'(bus.overrun), 8'd0);
            end
            if (mode == 3 && c == 1650) rst_n = 1'b1;
            @(negedge clk);
        end
        rd_stim = 1'b0;
        clr_stim = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        auto_rd = 1'b1;
        i = 0;
        while (i < 4000 && (q.size() != 0 || bus.avail)) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_left"}, 8'(q.size()), 8'd0);
        chk({name, "_avail"}, 8'(bus.avail), 8'd0);
        chk({name, "_dout"}, bus.dout, 8'h00);
        auto_rd = 1'b0;
    endtask

    task automatic clear_flags();
        clr_stim = 1'b1;
        @(negedge clk);
        clr_stim = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (auto_rd && bus.avail) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_extra: got %0h expected none",
                             bus.dout);
                end else begin
                    chk("rx_byte", bus.dout, q.pop_front());
                end
                rd_mon = 1'b1;
                @(negedge clk);
                rd_mon = 1'b0;
            end
        end
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_dout", bus.dout, 8'h00);
        chk("reset_avail", 8'(bus.avail), 8'd0);
        chk("reset_ovr", 8'(bus.overrun), 8'd0);
        chk("reset_ferr", 8'(bus.ferr), 8'd0);
        chk("reset_busy", 8'(busy), 8'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // basic bytes
        q.push_back(8'h55);
        send(8'h55, 1'b1, 0);
        q.push_back(8'hA3);
        send(8'hA3, 1'b1, 0);
        chk("basic_avail", 8'(bus.avail), 8'd1);
        drain("basic");
        chk("basic_ferr", 8'(bus.ferr), 8'd0);
        chk("basic_ovr", 8'(bus.overrun), 8'd0);

        // false start glitch
        RxD = 1'b0;
        repeat (50) @(negedge clk);
        chk("glitch_busy", 8'(busy), 8'd1);
        repeat (50) @(negedge clk);
        RxD = 1'b1;
        repeat (80) @(negedge clk);
        chk("glitch_idle", 8'(busy), 8'd0);
        chk("glitch_avail", 8'(bus.avail), 8'd0);
        chk("glitch_ferr", 8'(bus.ferr), 8'd0);
        q.push_back(8'h3C);
        send(8'h3C, 1'b1, 0);
        drain("after_glitch");

        // framing error and break
        send(8'h81, 1'b0, 0);
        repeat (3 * BIT_CLK) @(negedge clk);
        chk("frm_ferr", 8'(bus.ferr), 8'd1);
        chk("frm_break", 8'(busy), 8'd1);
        chk("frm_avail", 8'(bus.avail), 8'd0);
        RxD = 1'b1;
        repeat (10) @(negedge clk);
        chk("frm_idle", 8'(busy), 8'd0);
        q.push_back(8'h7E);
        send(8'h7E, 1'b1, 0);
        drain("after_frm");
        chk("frm_sticky", 8'(bus.ferr), 8'd1);
        clear_flags();
        chk("frm_clr", 8'(bus.ferr), 8'd0);

        // overrun
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) q.push_back(8'(i));
            send(8'(i), 1'b1, 0);
            if (i == 4) chk("ovr_pre", 8'(bus.overrun), 8'd0);
        end
        chk("ovr_set", 8'(bus.overrun), 8'd1);
        drain("ovr");
        clear_flags();
        chk("ovr_clr", 8'(bus.overrun), 8'd0);

        // full plus simultaneous pop, then clr vs new overrun
        for (int i = 1; i <= 4; i++) begin
            q.push_back(8'(i));
            send(8'(i), 1'b1, 0);
        end
        send(8'h05, 1'b1, 1);
        q.push_back(8'h05);
        chk("simul_ovr", 8'(bus.overrun), 8'd0);
        send(8'h06, 1'b1, 2);
        chk("clr_vs_set", 8'(bus.overrun), 8'd1);
        drain("simul");
        clear_flags();

        // reset mid-frame, FIFO content lost
        send(8'h11, 1'b1, 0);
        chk("pre_rst_avail", 8'(bus.avail), 8'd1);
        send(8'hF0, 1'b1, 3);
        chk("post_rst_avail", 8'(bus.avail), 8'd0);
        chk("post_rst_busy", 8'(busy), 8'd0);
        q.push_back(8'h99);
        send(8'h99, 1'b1, 0);
        drain("after_rst");
        chk("end_ferr", 8'(bus.ferr), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
